rr_bus_arbiter: RTL and testbench
=================================

# rr_bus_arbiter

Round-robin arbiter for the shared serial bus: it accepts up to twelve master requests, issues a one-hot grant, tracks the granted master's use of the bus utilization line, and revokes grants that are never used. It replaces the fixed-priority bus controller between the masters' `b_request`/`b_grant` pins and the pull-down `b_bus_utilizing` line. It also exposes the current master ID and state for the seven-segment displays and the busy multiplexer.

## Interface
- `N_MASTERS`, 12: number of request/grant lines; legal range 2–16.
- `ID_WIDTH`, 4: width of `mid_current`; must satisfy `2**ID_WIDTH >= N_MASTERS`.
- `TIMEOUT_LEN`, 6: grant-timeout counter width in bits. An unused grant is revoked after `2**TIMEOUT_LEN` cycles.

- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: **synchronous, active-high** reset.
- `m_reqs` in N_MASTERS: request lines. Bit i is master i.
- `m_enable` in N_MASTERS: per-master enable mask. A request is eligible only when `m_reqs[i] & m_enable[i]`.
- `bus_util` in 1: bus utilization line, driven high by the granted master for the whole transfer.
- `m_grants` out N_MASTERS: one-hot or all-zero grant.
- `mid_current` out ID_WIDTH: index of the most recently granted master.
- `state` out 2: 0 IDLE, 1 GRANT, 2 BUSY, 3 RELEASE.
- `timeout_evt` out 1: one-cycle pulse when a grant is revoked for non-use.
- `grant_count` out 16: total grants issued; wraps modulo 2^16.

## Operation
- **Reset values:** `state`=IDLE, `m_grants`=0, `mid_current`=0, `timeout_evt`=0, `grant_count`=0, round-robin pointer `ptr`=0, timeout counter=0.
- **IDLE**
  - Let `elig = m_reqs & m_enable`.
  - If `elig` is nonzero, select the first set bit searching upward from `ptr`, wrapping from index N_MASTERS-1 to 0. Call it `w`.
  - Register `m_grants = 1<<w`, `mid_current = w`, `ptr = (w+1) mod N_MASTERS`, and increment `grant_count`. Clear the timeout counter. Go to GRANT.
  - If `elig` is zero, stay in IDLE.
- **GRANT**
  - If `bus_util` is 1, go to BUSY.
  - Else, if the granted master's request has dropped, go to RELEASE. This applies whether the request was withdrawn or masked off by `m_enable`.
  - Else, if the counter equals `2**TIMEOUT_LEN-1`, go to RELEASE and pulse `timeout_evt` in the same registered update.
  - Otherwise increment the counter.
  - Priority order is: `bus_util`, then request drop, then timeout.
- **BUSY**
  - The grant is held regardless of `m_reqs` and `m_enable`.
  - When `bus_util` is 0, go to RELEASE.
  - There is no preemption, so a serial transfer is never cut.
- **RELEASE**
  - `m_grants` is all zero for exactly one cycle, giving a bus turnaround gap. Then go to IDLE.
  - `mid_current` keeps its value through RELEASE and IDLE.
- **Invariants**
  - `m_grants` is never multi-hot.
  - `m_grants` is nonzero only in GRANT and BUSY.
  - `mid_current` always equals the index of the set grant bit whenever `m_grants` is nonzero.
- `ptr` advances only on grant, so a timed-out master goes to the back of the rotation.
- Requests for indices >= N_MASTERS do not exist. The pointer wrap uses N_MASTERS, not a power of two.

## Timing
- **Request to grant:** a request sampled in IDLE gives a grant on the next edge (1-cycle latency).
- **Back-to-back transfers:** the minimum grant-to-grant spacing after a transfer is BUSY exit, then RELEASE (1 cycle), then IDLE arbitration (1 cycle). That is 2 cycles of all-zero grant between transfers.
- **Timeout:** a grant with `bus_util` never asserted lasts exactly `2**TIMEOUT_LEN` cycles in GRANT (64 with the default).
  - `timeout_evt` is high during the first RELEASE cycle only.
- **`bus_util` and timeout on the same cycle:** if `bus_util` rises on the cycle the counter reaches terminal count, the arbiter enters BUSY. No timeout is flagged.
- **Reset mid-operation:** `rst` asserted in any state returns all outputs and `ptr` to their reset values on the next edge. The grant is dropped immediately.
- All outputs are registered. There is no combinational path from the inputs to `m_grants`.

## Test plan
- **Rotation:** after reset, hold `m_reqs`=12'h034 (masters 2, 4, 5) and pulse `bus_util` high for 3 cycles after each grant.
  - Grants are issued in order 2, 4, 5, 2, 4.
  - `mid_current` follows 2, 4, 5, 2, 4, and `grant_count` reaches 5.
  - There are 2 zero-grant cycles between grants.
- **Timeout:** request master 4 only and never assert `bus_util`.
  - The grant lasts 64 cycles.
  - `timeout_evt` pulses once, then master 4 is re-granted 2 cycles later.
- **Masking:** set `m_reqs`=12'h034 and `m_enable`=12'hFEF.
  - Master 4 is never granted; grants alternate 2, 5.
  - Clearing the master 2 bit of `m_enable` (bit 2) while in GRANT for master 2 gives RELEASE on the next cycle.
- **Held transfer:** master 5 holds `bus_util` for 100 cycles while masters 2 and 4 request and master 5 drops its request.
  - The grant stays on master 5 until `bus_util` falls.
  - The next grant goes to master 2, because `ptr` wrapped after master 5.
- **Reset mid-operation:** assert `rst` for 1 cycle while in BUSY for master 4.
  - On the next edge `m_grants`=0, `state`=0, `mid_current`=0, `grant_count`=0.
  - The following grant goes to the lowest eligible index.
- **Simultaneous `bus_util` and timeout:** raise `bus_util` exactly on GRANT cycle 64.
  - `state` becomes BUSY and `timeout_evt` stays 0.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter
//   Round-robin arbiter for the shared serial bus. Issues a one-hot grant to
//   the next eligible master after the rotation pointer, holds it while the
//   master drives the bus utilization line, revokes grants that go unused,
//   and inserts a one-cycle all-zero turnaround gap after every grant.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   m_reqs       per-master request lines (bit i = master i)
//   m_enable     per-master enable mask; eligible = m_reqs & m_enable
//   bus_util     bus utilization line from the granted master
//   m_grants     registered one-hot / all-zero grant
//   mid_current  index of the most recently granted master
//   state        0 IDLE, 1 GRANT, 2 BUSY, 3 RELEASE
//   timeout_evt  one-cycle pulse in the RELEASE cycle after an unused grant
//   grant_count  number of grants issued, wraps modulo 2^16
module rr_bus_arbiter #(
  parameter int unsigned N_MASTERS   = 12,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned TIMEOUT_LEN = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] m_reqs,
  input  logic [N_MASTERS-1:0] m_enable,
  input  logic                 bus_util,
  output logic [N_MASTERS-1:0] m_grants,
  output logic [ID_WIDTH-1:0]  mid_current,
  output logic [1:0]           state,
  output logic                 timeout_evt,
  output logic [15:0]          grant_count
);

  localparam int unsigned IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                 r_state, w_state_n;
  logic [N_MASTERS-1:0]   r_grants, w_grants_n;
  logic [ID_WIDTH-1:0]    r_mid, w_mid_n;
  logic [ID_WIDTH-1:0]    r_ptr, w_ptr_n;
  logic [TIMEOUT_LEN-1:0] r_cnt, w_cnt_n;
  logic                   r_tevt, w_tevt_n;
  logic [15:0]            r_gcnt, w_gcnt_n;

  logic [N_MASTERS-1:0]   w_elig;
  logic                   w_found;
  logic [IW-1:0]          w_win;
  logic [ID_WIDTH-1:0]    w_ptr_next;
  logic                   w_granted_elig;

  assign w_elig         = m_reqs & m_enable;
  assign w_granted_elig = w_elig[r_mid[IW-1:0]];

  // Search upward from the pointer, wrapping at N_MASTERS (not a power of two).
  always_comb begin
    int unsigned idx;
    idx        = 0;
    w_found    = 1'b0;
    w_win      = '0;
    w_ptr_next = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!w_found && w_elig[idx[IW-1:0]]) begin
        w_found    = 1'b1;
        w_win      = idx[IW-1:0];
        w_ptr_next = (idx + 1 >= N_MASTERS) ? '0 : ID_WIDTH'(idx + 1);
      end
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_grants_n = r_grants;
    w_mid_n    = r_mid;
    w_ptr_n    = r_ptr;
    w_cnt_n    = r_cnt;
    w_tevt_n   = 1'b0;
    w_gcnt_n   = r_gcnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_n         = S_GRANT;
          w_grants_n        = '0;
          w_grants_n[w_win] = 1'b1;
          w_mid_n           = ID_WIDTH'(w_win);
          w_ptr_n           = w_ptr_next;
          w_gcnt_n          = r_gcnt + 16'd1;
          w_cnt_n           = '0;
        end
      end
      S_GRANT: begin
        // bus_util wins over request drop, which wins over timeout.
        if (bus_util) begin
          w_state_n = S_BUSY;
        end else if (!w_granted_elig) begin
          w_state_n  = S_RELEASE;
          w_grants_n = '0;
        end else if (r_cnt == '1) begin
          w_state_n  = S_RELEASE;
          w_grants_n = '0;
          w_tevt_n   = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_BUSY: begin
        if (!bus_util) begin
          w_state_n  = S_RELEASE;
          w_grants_n = '0;
        end
      end
      S_RELEASE: begin
        w_state_n  = S_IDLE;
        w_grants_n = '0;
      end
      default: begin
        w_state_n  = S_IDLE;
        w_grants_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grants <= '0;
      r_mid    <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_tevt   <= 1'b0;
      r_gcnt   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_grants <= w_grants_n;
      r_mid    <= w_mid_n;
      r_ptr    <= w_ptr_n;
      r_cnt    <= w_cnt_n;
      r_tevt   <= w_tevt_n;
      r_gcnt   <= w_gcnt_n;
    end
  end

  assign m_grants    = r_grants;
  assign mid_current = r_mid;
  assign state       = r_state;
  assign timeout_evt = r_tevt;
  assign grant_count = r_gcnt;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter
//   Directed scenarios for rotation, timeout, masking, held transfers, reset
//   and the bus_util/timeout race, followed by randomized traffic compared
//   against a cycle-level behavioural model of the arbitration rules.
module tb_rr_bus_arbiter;

  localparam int N  = 12;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  m_reqs;
  logic [N-1:0]  m_enable;
  logic          bus_util;
  logic [N-1:0]  m_grants;
  logic [3:0]    mid_current;
  logic [1:0]    state;
  logic          timeout_evt;
  logic [15:0]   grant_count;

  int checks = 0;
  int errors = 0;

  rr_bus_arbiter #(.N_MASTERS(12), .ID_WIDTH(4), .TIMEOUT_LEN(6)) dut (
    .clk(clk), .rst(rst), .m_reqs(m_reqs), .m_enable(m_enable),
    .bus_util(bus_util), .m_grants(m_grants), .mid_current(mid_current),
    .state(state), .timeout_evt(timeout_evt), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: state as a small integer, grant age counted in cycles.
  int           md_state = 0;
  logic [N-1:0] md_grants = '0;
  int           md_mid = 0, md_ptr = 0, md_age = 0, md_gc = 0, md_w = 0;
  logic         md_tevt = 1'b0;
  logic [N-1:0] md_elig;

  always @(posedge clk) begin
    if (rst) begin
      md_state = 0; md_grants = '0; md_mid = 0; md_ptr = 0;
      md_age = 0; md_tevt = 1'b0; md_gc = 0;
    end else begin
      md_tevt = 1'b0;
      md_elig = m_reqs & m_enable;
      case (md_state)
        0: if (md_elig != '0) begin
             md_w = -1;
             for (int k = 0; k < N; k++)
               if (md_w < 0 && md_elig[(md_ptr + k) % N]) md_w = (md_ptr + k) % N;
             md_grants = '0; md_grants[md_w] = 1'b1;
             md_mid = md_w; md_ptr = (md_w + 1) % N;
             md_gc = (md_gc + 1) % 65536; md_age = 1; md_state = 1;
           end
        1: if (bus_util) md_state = 2;
           else if (!md_elig[md_mid]) begin md_state = 3; md_grants = '0; end
           else if (md_age == TO) begin md_state = 3; md_grants = '0; md_tevt = 1'b1; end
           else md_age = md_age + 1;
        2: if (!bus_util) begin md_state = 3; md_grants = '0; end
        default: md_state = 0;
      endcase
    end
  end

  task automatic test_reset();
    rst = 1'b1; m_reqs = '0; m_enable = '1; bus_util = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (m_grants !== 12'h000) begin errors++; $display("FAIL reset_grants: got %h expected 000", m_grants); end
    checks++; if (mid_current !== 4'd0) begin errors++; $display("FAIL reset_mid: got %0d expected 0", mid_current); end
    checks++; if (grant_count !== 16'd0 || timeout_evt !== 1'b0) begin
      errors++; $display("FAIL reset_count_evt: got %0d/%b expected 0/0", grant_count, timeout_evt);
    end
  endtask

  task automatic test_rotation();
    int exp_seq[5] = '{2, 4, 5, 2, 4};
    int zeros;
    logic [N-1:0] exp_g;
    m_reqs = 12'h034;
    for (int g = 0; g < 5; g++) begin
      zeros = 0;
      @(negedge clk);
      while (m_grants == '0 && zeros < 20) begin zeros++; @(negedge clk); end
      exp_g = '0; exp_g[exp_seq[g]] = 1'b1;
      checks++; if (m_grants !== exp_g || mid_current !== 4'(exp_seq[g])) begin
        errors++; $display("FAIL rotation_grant%0d: got %h/%0d expected %h/%0d", g, m_grants, mid_current, exp_g, exp_seq[g]);
      end
      if (g > 0) begin
        checks++; if (zeros != 2) begin errors++; $display("FAIL rotation_gap%0d: got %0d expected 2", g, zeros); end
      end
      bus_util = 1'b1;
      repeat (3) @(negedge clk);
      bus_util = 1'b0;
    end
    m_reqs = '0;
    checks++; if (grant_count !== 16'd5) begin errors++; $display("FAIL rotation_count: got %0d expected 5", grant_count); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int len;
    m_reqs = 12'h010;
    @(negedge clk);
    len = 0;
    while (m_grants == 12'h010 && len < 200) begin len++; @(negedge clk); end
    checks++; if (len != TO) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", len, TO); end
    checks++; if (timeout_evt !== 1'b1 || state !== 2'd3) begin
      errors++; $display("FAIL timeout_pulse: got %b/%0d expected 1/3", timeout_evt, state);
    end
    @(negedge clk);
    checks++; if (timeout_evt !== 1'b0 || m_grants !== '0) begin
      errors++; $display("FAIL timeout_single: got %b/%h expected 0/000", timeout_evt, m_grants);
    end
    @(negedge clk);
    checks++; if (m_grants !== 12'h010) begin errors++; $display("FAIL timeout_regrant: got %h expected 010", m_grants); end
    m_reqs = '0;
    @(negedge clk);
    checks++; if (state !== 2'd3 || timeout_evt !== 1'b0) begin
      errors++; $display("FAIL drop_release: got %0d/%b expected 3/0", state, timeout_evt);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_masking();
    int exp_seq[6] = '{5, 2, 5, 2, 5, 2};
    int wait_n;
    logic [N-1:0] exp_g;
    m_reqs = 12'h034; m_enable = 12'hFEF;
    for (int g = 0; g < 6; g++) begin
      wait_n = 0;
      @(negedge clk);
      while (m_grants == '0 && wait_n < 20) begin wait_n++; @(negedge clk); end
      exp_g = '0; exp_g[exp_seq[g]] = 1'b1;
      checks++; if (m_grants !== exp_g) begin
        errors++; $display("FAIL mask_grant%0d: got %h expected %h", g, m_grants, exp_g);
      end
      if (g < 5) begin
        bus_util = 1'b1; repeat (2) @(negedge clk); bus_util = 1'b0;
      end
    end
    m_enable = 12'hFEB;
    @(negedge clk);
    checks++; if (state !== 2'd3 || m_grants !== '0) begin
      errors++; $display("FAIL mask_release: got %0d/%h expected 3/000", state, m_grants);
    end
    m_reqs = '0; m_enable = '1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_held();
    int bad, zeros;
    m_reqs = 12'h020;
    @(negedge clk);
    checks++; if (m_grants !== 12'h020) begin errors++; $display("FAIL held_first: got %h expected 020", m_grants); end
    bus_util = 1'b1; m_reqs = 12'h014;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_grants !== 12'h020 || state !== 2'd2) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL held_hold: got %0d bad cycles expected 0", bad); end
    bus_util = 1'b0;
    zeros = 0;
    @(negedge clk);
    while (m_grants == '0 && zeros < 20) begin zeros++; @(negedge clk); end
    checks++; if (m_grants !== 12'h004 || zeros != 2) begin
      errors++; $display("FAIL held_next: got %h gap %0d expected 004 gap 2", m_grants, zeros);
    end
  endtask

  task automatic test_reset_mid();
    int wait_n;
    bus_util = 1'b1; repeat (2) @(negedge clk); bus_util = 1'b0;
    wait_n = 0;
    @(negedge clk);
    while (m_grants == '0 && wait_n < 20) begin wait_n++; @(negedge clk); end
    checks++; if (m_grants !== 12'h010) begin errors++; $display("FAIL rstmid_grant4: got %h expected 010", m_grants); end
    bus_util = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rstmid_busy: got %0d expected 2", state); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_grants !== '0 || state !== 2'd0 || mid_current !== 4'd0 || grant_count !== 16'd0) begin
      errors++; $display("FAIL rstmid_clear: got %h/%0d/%0d/%0d expected 000/0/0/0", m_grants, state, mid_current, grant_count);
    end
    rst = 1'b0; bus_util = 1'b0;
    @(negedge clk);
    checks++; if (m_grants !== 12'h004 || grant_count !== 16'd1) begin
      errors++; $display("FAIL rstmid_lowest: got %h/%0d expected 004/1", m_grants, grant_count);
    end
    m_reqs = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simul();
    m_reqs = 12'h080;
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    checks++; if (m_grants !== 12'h080 || state !== 2'd1) begin
      errors++; $display("FAIL simul_pre: got %h/%0d expected 080/1", m_grants, state);
    end
    bus_util = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd2 || timeout_evt !== 1'b0 || m_grants !== 12'h080) begin
      errors++; $display("FAIL simul_busy: got %0d/%b/%h expected 2/0/080", state, timeout_evt, m_grants);
    end
    bus_util = 1'b0; m_reqs = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int printed = 0;
    int bad;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) m_reqs = N'($urandom);
      if ($urandom_range(0, 31) == 0) m_enable = N'($urandom) | 12'h0F0;
      if (c % 800 < 200) bus_util = 1'b0;
      else bus_util = ($urandom_range(0, 9) < 4);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      bad = 0;
      checks++; if (m_grants !== md_grants) bad++;
      checks++; if (state !== 2'(md_state)) bad++;
      checks++; if (mid_current !== 4'(md_mid)) bad++;
      checks++; if (timeout_evt !== md_tevt) bad++;
      checks++; if (grant_count !== 16'(md_gc)) bad++;
      errors += bad;
      if (bad != 0 && printed < 10) begin
        printed++;
        $display("FAIL random_cycle%0d: got g=%h s=%0d m=%0d t=%b c=%0d expected g=%h s=%0d m=%0d t=%b c=%0d",
                 c, m_grants, state, mid_current, timeout_evt, grant_count,
                 md_grants, md_state, md_mid, md_tevt, md_gc);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; m_reqs = '0; m_enable = '1; bus_util = 1'b0;
    test_reset();
    test_rotation();
    test_timeout();
    test_masking();
    test_held();
    test_reset_mid();
    test_simul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
